firo_sampler_ctrl: RTL and testbench

FIRO_SAMPLER_CTRL -- requirements
Module: firo_sampler_ctrl

---
 rtl/firo_sampler_ctrl_pkg.sv | 17 +
 rtl/firo_rct_monitor.sv | 45 ++++
 rtl/firo_sampler_ctrl.sv | 157 +++++++++++++++
 tb/tb_firo_sampler_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/firo_sampler_ctrl_pkg.sv
// Shared types and default parameters for the FiRO sampler controller.
package firo_sampler_ctrl_pkg;

    localparam int DEF_WARMUP_CYCLES = 256;
    localparam int DEF_DECIM         = 8;
    localparam int DEF_WORD_W        = 32;
    localparam int DEF_RCT_LIMIT     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_SAMPLE,
        ST_HOLD,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/firo_rct_monitor.sv
// Repetition count health test on the captured raw bit stream.
// fail pulses in the capture cycle whose bit makes the run reach the limit,
// so the controller can react on the same edge that stores the bit.
module firo_rct_monitor
    import firo_sampler_ctrl_pkg::*;
#(
    parameter int RCT_LIMIT = DEF_RCT_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_val,
    input  logic bit_stb,
    input  logic restart,
    output logic fail
);

    localparam logic [7:0] LIMIT = 8'(RCT_LIMIT);

    // run_cnt == 0 marks "no previous bit", so the next capture starts a run of 1
    logic [7:0] run_cnt;
    logic       last_bit;
    logic [7:0] run_next;

    // run length after accepting the current bit (saturating)
    always_comb begin
        run_next = 8'd1;
        if (run_cnt != 8'd0 && bit_val == last_bit)
            run_next = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
        fail = bit_stb && (run_next >= LIMIT);
    end

    // track run length and last bit; restart forgets history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt  <= 8'd0;
            last_bit <= 1'b0;
        end else if (restart) begin
            run_cnt  <= 8'd0;
        end else if (bit_stb) begin
            run_cnt  <= run_next;
            last_bit <= bit_val;
        end
    end

endmodule

// File: rtl/firo_sampler_ctrl.sv
// FiRO sampler controller: warms up the oscillator, strobes its sample
// register every DECIM cycles, packs captured bits LSB-first into words and
// runs a repetition count health test on the stream.
module firo_sampler_ctrl
    import firo_sampler_ctrl_pkg::*;
#(
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int DECIM         = DEF_DECIM,
    parameter int WORD_W        = DEF_WORD_W,
    parameter int RCT_LIMIT     = DEF_RCT_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear_fail,
    output logic              osc_en,
    output logic              dff_en,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              health_fail
);

    localparam int               IDX_W     = $clog2(WORD_W);
    localparam logic [15:0]      WARM_LAST = 16'(WARMUP_CYCLES - 1);
    localparam logic [7:0]       DEC_LAST  = 8'(DECIM - 1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(WORD_W - 1);

    state_t           state;
    logic [15:0]      warm_cnt;
    logic [7:0]       dec_cnt;
    logic [7:0]       dec_next;
    logic [IDX_W-1:0] bit_cnt;
    logic             pend;       // FiRO output is valid this cycle (strobed last cycle)
    logic             active;
    logic             cap;
    logic             warm_done;
    logic             rct_fail;

    // decode of the current cycle's events
    always_comb begin
        active    = (state == ST_WARMUP) || (state == ST_SAMPLE) || (state == ST_HOLD);
        cap       = (state == ST_SAMPLE) && pend && !stop;
        warm_done = (state == ST_WARMUP) && !stop && (warm_cnt == WARM_LAST);
        dec_next  = (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
    end

    firo_rct_monitor #(
        .RCT_LIMIT (RCT_LIMIT)
    ) u_rct (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_val (raw_bit),
        .bit_stb (cap),
        .restart (warm_done),
        .fail    (rct_fail)
    );

    // main FSM with registered outputs; stop from an active state beats
    // everything else (including an RCT failure and a pending capture)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            warm_cnt    <= 16'd0;
            dec_cnt     <= 8'd0;
            bit_cnt     <= '0;
            pend        <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            osc_en      <= 1'b0;
            dff_en      <= 1'b0;
            busy        <= 1'b0;
            health_fail <= 1'b0;
        end else if (stop && active) begin
            // a HOLD transfer in this cycle still completes on the consumer side
            state      <= ST_IDLE;
            warm_cnt   <= 16'd0;
            dec_cnt    <= 8'd0;
            bit_cnt    <= '0;
            pend       <= 1'b0;
            word_data  <= '0;
            word_valid <= 1'b0;
            osc_en     <= 1'b0;
            dff_en     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_WARMUP;
                        warm_cnt <= 16'd0;
                        osc_en   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (warm_done) begin
                        state     <= ST_SAMPLE;
                        dec_cnt   <= 8'd0;
                        bit_cnt   <= '0;
                        pend      <= 1'b0;
                        word_data <= '0;
                        dff_en    <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (cap) begin
                        word_data[bit_cnt] <= raw_bit;
                        bit_cnt            <= bit_cnt + IDX_W'(1);
                    end
                    if (cap && rct_fail) begin
                        // health failure takes precedence over a completed word
                        state       <= ST_FAIL;
                        osc_en      <= 1'b0;
                        busy        <= 1'b0;
                        health_fail <= 1'b1;
                        dff_en      <= 1'b0;
                        pend        <= 1'b0;
                    end else if (cap && bit_cnt == BIT_LAST) begin
                        state      <= ST_HOLD;
                        word_valid <= 1'b1;
                        dff_en     <= 1'b0;
                        pend       <= 1'b0;
                    end else begin
                        dec_cnt <= dec_next;
                        dff_en  <= (dec_next == DEC_LAST);
                        pend    <= dff_en;
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        state      <= ST_SAMPLE;
                        word_valid <= 1'b0;
                        word_data  <= '0;
                        bit_cnt    <= '0;
                        dec_cnt    <= 8'd0;
                    end
                end
                ST_FAIL: begin
                    if (clear_fail) begin
                        state       <= ST_IDLE;
                        health_fail <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_firo_sampler_ctrl.sv
// Self-checking bench for firo_sampler_ctrl: directed scenarios plus a
// randomized run, all compared every cycle against a phase/time based model.
module tb_firo_sampler_ctrl;

    localparam int WU = 4;
    localparam int DC = 2;
    localparam int WW = 8;
    localparam int RL = 4;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_SAMP = 2;
    localparam int M_HOLD = 3;
    localparam int M_FAIL = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, stop, clear_fail, raw_bit, word_ready;
    logic          osc_en, dff_en, word_valid, busy, health_fail;
    logic [WW-1:0] word_data;

    always #5 clk = ~clk;

    firo_sampler_ctrl #(
        .WARMUP_CYCLES (WU),
        .DECIM         (DC),
        .WORD_W        (WW),
        .RCT_LIMIT     (RL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .clear_fail  (clear_fail),
        .osc_en      (osc_en),
        .dff_en      (dff_en),
        .raw_bit     (raw_bit),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .health_fail (health_fail)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // reference model: mode, cycles spent in the current phase, captured bits
    int m_mode = M_IDLE;
    int m_t    = 0;
    int m_run  = 0;
    bit m_last = 1'b0;
    bit m_dff  = 1'b0;   // strobe expected in the current cycle
    bit m_dff1 = 1'b0;   // strobe seen in the previous cycle
    bit m_bits[$];

    int cyc_n = 0, cap_cnt = 0, last_cap_edge = 0, xfer_cnt = 0;
    bit src_q[$];
    bit src_const = 1'b0;

    function automatic logic [63:0] exp_word();
        logic [63:0] w;
        w = 64'd0;
        foreach (m_bits[k]) w[k] = m_bits[k];
        return w;
    endfunction

    task automatic model_step();
        bit cap, fail;
        cap    = m_dff1;
        m_dff1 = m_dff;
        if (!rst_n) begin
            m_mode = M_IDLE; m_t = 0; m_run = 0; m_dff1 = 1'b0;
            m_bits.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin m_mode = M_WARM; m_t = 0; end
                M_WARM: begin
                    if (stop) m_mode = M_IDLE;
                    else begin
                        m_t++;
                        if (m_t == WU) begin
                            m_mode = M_SAMP; m_t = 0; m_run = 0; m_bits.delete();
                        end
                    end
                end
                M_SAMP: begin
                    if (stop) begin
                        m_mode = M_IDLE; m_bits.delete();
                    end else begin
                        fail = 1'b0;
                        if (cap) begin
                            m_run  = (m_run == 0 || raw_bit != m_last) ? 1 : m_run + 1;
                            m_last = raw_bit;
                            m_bits.push_back(raw_bit);
                            fail = (m_run >= RL);
                        end
                        if (fail) m_mode = M_FAIL;
                        else if (m_bits.size() == WW) m_mode = M_HOLD;
                        else m_t++;
                    end
                end
                M_HOLD: begin
                    if (word_ready) begin
                        m_mode = stop ? M_IDLE : M_SAMP;
                        m_t = 0;
                        m_bits.delete();
                    end else if (stop) begin
                        m_mode = M_IDLE;
                    end
                end
                default: if (clear_fail) m_mode = M_IDLE;
            endcase
        end
        m_dff = (m_mode == M_SAMP) && (m_t % DC == DC - 1);
    endtask

    task automatic compare_all();
        bit act;
        act = (m_mode == M_WARM) || (m_mode == M_SAMP) || (m_mode == M_HOLD);
        chk("osc_en", 64'(osc_en), 64'(act));
        chk("busy", 64'(busy), 64'(act));
        chk("dff_en", 64'(dff_en), 64'(m_dff));
        chk("health_fail", 64'(health_fail), 64'(m_mode == M_FAIL));
        chk("word_valid", 64'(word_valid), 64'(m_mode == M_HOLD));
        if (m_mode == M_HOLD) chk("word_data", 64'(word_data), exp_word());
    endtask

    function automatic bit next_src();
        if (src_q.size() > 0) return src_q.pop_front();
        if (src_const) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // one clock: bookkeeping, edge, model update, compare, release pulses
    task automatic cyc();
        if (rst_n && m_mode == M_SAMP && m_dff1 && !stop) begin
            cap_cnt++;
            last_cap_edge = cyc_n + 1;
        end
        if (word_valid === 1'b1 && word_ready) xfer_cnt++;
        @(posedge clk);
        model_step();
        cyc_n++;
        @(negedge clk);
        compare_all();
        start = 1'b0; stop = 1'b0; clear_fail = 1'b0; rst_n = 1'b1;
        // meaningful bit only in the cycle after a strobe, junk otherwise
        if (m_mode == M_SAMP && m_dff1) raw_bit = next_src();
        else raw_bit = 1'($urandom_range(0, 1));
    endtask

    task automatic rst_outputs_zero(input string tag);
        chk({tag, "_osc"}, 64'(osc_en), 64'd0);
        chk({tag, "_dff"}, 64'(dff_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hf"}, 64'(health_fail), 64'd0);
        chk({tag, "_valid"}, 64'(word_valid), 64'd0);
        chk({tag, "_data"}, 64'(word_data), 64'd0);
    endtask

    initial begin
        int s, r;
        bit seen_valid;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear_fail = 1'b0;
        raw_bit = 1'b0; word_ready = 1'b0;
        rst_n = 1'b0; cyc();
        rst_n = 1'b0; cyc();
        rst_outputs_zero("reset");

        // known bit pattern, first strobe latency, word value, HOLD back-pressure
        src_q = '{1, 0, 1, 1, 0, 0, 1, 0};
        start = 1'b1; cyc(); s = cyc_n;
        for (int i = 0; i < 50 && !dff_en; i++) cyc();
        chk("first_dff_lat", 64'(cyc_n - s), 64'(WU + DC - 1));
        for (int i = 0; i < 100 && !word_valid; i++) cyc();
        chk("word_4d", 64'(word_data), 64'h4D);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_data", 64'(word_data), 64'h4D);
            chk("hold_dff", 64'(dff_en), 64'd0);
            chk("hold_osc", 64'(osc_en), 64'd1);
        end
        // latency counted from the cycle ready is presented
        word_ready = 1'b1; r = cyc_n; cyc(); word_ready = 1'b0;
        for (int i = 0; i < 50 && !dff_en; i++) cyc();
        chk("ready_dff_lat", 64'(cyc_n - r), 64'(DC));
        stop = 1'b1; cyc();
        chk("stop_idle", 64'(busy), 64'd0);

        // constant bits trip the health test on the RL-th capture
        src_q.delete(); src_const = 1'b1;
        start = 1'b1; cyc(); cap_cnt = 0;
        for (int i = 0; i < 100 && !health_fail; i++) cyc();
        chk("rct_caps", 64'(cap_cnt), 64'(RL));
        chk("rct_when", 64'(cyc_n), 64'(last_cap_edge));
        chk("fail_osc", 64'(osc_en), 64'd0);
        stop = 1'b1; cyc(); start = 1'b1; cyc(); cyc();
        chk("fail_sticky", 64'(health_fail), 64'd1);
        clear_fail = 1'b1; cyc();
        chk("clear_hf", 64'(health_fail), 64'd0);
        src_const = 1'b0;

        // stop on the fifth bit discards the word; restart does full warm-up
        src_q = '{0, 1, 0, 1, 0, 1, 0, 1};
        start = 1'b1; cyc(); cap_cnt = 0;
        for (int i = 0; i < 100 && cap_cnt < 4; i++) cyc();
        stop = 1'b1; cyc();
        chk("stop5_busy", 64'(busy), 64'd0);
        chk("stop5_osc", 64'(osc_en), 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(); seen_valid |= word_valid; end
        chk("stop5_novalid", 64'(seen_valid), 64'd0);
        src_q.delete();
        start = 1'b1; cyc(); s = cyc_n;
        for (int i = 0; i < 50 && !dff_en; i++) cyc();
        chk("restart_lat", 64'(cyc_n - s), 64'(WU + DC - 1));

        // reset mid-word and in FAIL
        stop = 1'b1; cyc();
        start = 1'b1; cyc(); cap_cnt = 0;
        for (int i = 0; i < 100 && cap_cnt < 3; i++) cyc();
        rst_n = 1'b0; cyc();
        rst_outputs_zero("rst_sample");
        src_const = 1'b1;
        start = 1'b1; cyc();
        for (int i = 0; i < 100 && !health_fail; i++) cyc();
        chk("rst_fail_pre", 64'(health_fail), 64'd1);
        rst_n = 1'b0; cyc();
        rst_outputs_zero("rst_fail");
        src_const = 1'b0;

        // stop together with a transfer: one word goes out, then IDLE
        src_q = '{0, 1, 0, 1, 0, 1, 0, 1};
        start = 1'b1; cyc();
        for (int i = 0; i < 100 && !word_valid; i++) cyc();
        xfer_cnt = 0;
        word_ready = 1'b1; stop = 1'b1; cyc(); word_ready = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("xfer_once", 64'(xfer_cnt), 64'd1);
        chk("xfer_idle", 64'(busy), 64'd0);
        src_q.delete();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 5) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            clear_fail = ($urandom_range(0, 4) == 0);
            word_ready = 1'($urandom_range(0, 1));
            rst_n      = ($urandom_range(0, 399) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
